// File: rtl/pipeline_snapshot_streamer.sv
// pipeline_snapshot_streamer
// Stalls the datapath on request, reads the register file and a window of
// data memory through debug read ports, and streams the words out over a
// valid/ready interface, each tagged with its kind and index.
// Optional feature macro: SNAP_PC_EN (adds pc_in and a leading PC header word).
module pipeline_snapshot_streamer #(
    parameter int DATA_W    = 32,
    parameter int NREGS     = 8,
    parameter int MEM_WORDS = 2,
    parameter int MEM_BASE  = 0,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              snap_req,
    output logic              freeze,
    output logic              busy,
    output logic              req_overrun,
    output logic [5:0]        rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [ADDR_W-1:0] dm_raddr,
    input  logic [DATA_W-1:0] dm_rdata,
`ifdef SNAP_PC_EN
    input  logic [31:0]       pc_in,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_tag,
    output logic              out_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
`ifdef SNAP_PC_EN
        S_PCW,
`endif
        S_REGS,
        S_MEM,
        S_DRAIN
    } state_t;

    localparam logic [5:0] LAST_REG = 6'(NREGS - 1);
    localparam logic [5:0] LAST_MEM = 6'(MEM_WORDS - 1);

    state_t              state_q, state_d;
    logic [5:0]          idx_q, idx_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [7:0]          tag_q, tag_d;
    logic                overrun_q, overrun_d;
    logic                slot_free;

    // The output register can take a new word when it is empty or being drained.
    assign slot_free = !valid_q || out_ready;

    // Next-state, read-port addressing and output-register load decisions.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        last_d    = last_q;
        data_d    = data_q;
        tag_d     = tag_q;
        overrun_d = overrun_q;
        rf_raddr  = 6'd0;
        dm_raddr  = '0;

        // A request while a snapshot is running is dropped but remembered.
        if (state_q != S_IDLE && snap_req) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (snap_req) begin
                    state_d   = S_SETTLE;
                    overrun_d = 1'b0;
                    idx_d     = 6'd0;
                end
            end
            // One frozen cycle lets an in-flight writeback land before reading.
            S_SETTLE: begin
`ifdef SNAP_PC_EN
                state_d = S_PCW;
`else
                state_d = S_REGS;
`endif
            end
`ifdef SNAP_PC_EN
            S_PCW: begin
                if (slot_free) begin
                    valid_d = 1'b1;
                    data_d  = DATA_W'(pc_in);
                    tag_d   = 8'h00;
                    last_d  = 1'b0;
                    state_d = S_REGS;
                end
            end
`endif
            S_REGS: begin
                rf_raddr = idx_q;
                if (slot_free) begin
                    valid_d = 1'b1;
                    data_d  = rf_rdata;
                    tag_d   = {2'b01, idx_q};
                    last_d  = 1'b0;
                    if (idx_q == LAST_REG) begin
                        idx_d = 6'd0;
                        if (MEM_WORDS == 0) begin
                            last_d  = 1'b1;
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_MEM;
                        end
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            S_MEM: begin
                dm_raddr = ADDR_W'(MEM_BASE) + ADDR_W'({idx_q, 2'b00});
                if (slot_free) begin
                    valid_d = 1'b1;
                    data_d  = dm_rdata;
                    tag_d   = {2'b10, idx_q};
                    last_d  = 1'b0;
                    if (idx_q == LAST_MEM) begin
                        last_d  = 1'b1;
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any partial stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 6'd0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
            tag_q     <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign freeze      = busy;
    assign req_overrun = overrun_q;
    assign out_valid   = valid_q;
    assign out_last    = last_q;
    assign out_data    = data_q;
    assign out_tag     = tag_q;

endmodule

// File: tb/tb_pipeline_snapshot_streamer.sv
// Directed self-checking bench for pipeline_snapshot_streamer.
// Instance A uses default parameters; instance B dumps 2 regs and 3 memory
// words from byte address 0x100. Honours SNAP_PC_EN if defined.
module tb_pipeline_snapshot_streamer;

`ifdef SNAP_PC_EN
    localparam int NPC = 1;
`else
    localparam int NPC = 0;
`endif
    localparam int NA = NPC + 8 + 2;
    localparam int NB = NPC + 2 + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        snap;
    logic        out_ready;
    logic        sel;
    logic [31:0] pc_val = 32'h0000_001C;

    logic        a_freeze, a_busy, a_ovr, a_valid, a_last;
    logic [5:0]  a_rf;
    logic [31:0] a_dm, a_data, a_rf_rdata, a_dm_rdata;
    logic [7:0]  a_tag;
    logic        b_freeze, b_busy, b_ovr, b_valid, b_last;
    logic [5:0]  b_rf;
    logic [31:0] b_dm, b_data, b_rf_rdata, b_dm_rdata;
    logic [7:0]  b_tag;

    always #5 clk = ~clk;

    // Register file model R[i] = 10*i; memory A: Mem[0]=5, Mem[4]=9; memory B echoes its address.
    assign a_rf_rdata = {26'd0, a_rf} * 32'd10;
    assign a_dm_rdata = (a_dm == 32'd0) ? 32'd5 : (a_dm == 32'd4) ? 32'd9 : 32'hDEAD_BEEF;
    assign b_rf_rdata = {26'd0, b_rf} * 32'd10;
    assign b_dm_rdata = b_dm;

    pipeline_snapshot_streamer u_a (
        .clk(clk), .rst(rst), .snap_req(snap & ~sel),
        .freeze(a_freeze), .busy(a_busy), .req_overrun(a_ovr),
        .rf_raddr(a_rf), .rf_rdata(a_rf_rdata),
        .dm_raddr(a_dm), .dm_rdata(a_dm_rdata),
`ifdef SNAP_PC_EN
        .pc_in(pc_val),
`endif
        .out_valid(a_valid), .out_ready(out_ready),
        .out_data(a_data), .out_tag(a_tag), .out_last(a_last)
    );

    pipeline_snapshot_streamer #(.NREGS(2), .MEM_WORDS(3), .MEM_BASE(32'h100)) u_b (
        .clk(clk), .rst(rst), .snap_req(snap & sel),
        .freeze(b_freeze), .busy(b_busy), .req_overrun(b_ovr),
        .rf_raddr(b_rf), .rf_rdata(b_rf_rdata),
        .dm_raddr(b_dm), .dm_rdata(b_dm_rdata),
`ifdef SNAP_PC_EN
        .pc_in(pc_val),
`endif
        .out_valid(b_valid), .out_ready(out_ready),
        .out_data(b_data), .out_tag(b_tag), .out_last(b_last)
    );

    wire        m_freeze = sel ? b_freeze : a_freeze;
    wire        m_busy   = sel ? b_busy   : a_busy;
    wire        m_ovr    = sel ? b_ovr    : a_ovr;
    wire        m_valid  = sel ? b_valid  : a_valid;
    wire        m_last   = sel ? b_last   : a_last;
    wire [5:0]  m_rf     = sel ? b_rf     : a_rf;
    wire [31:0] m_dm     = sel ? b_dm     : a_dm;
    wire [31:0] m_data   = sel ? b_data   : a_data;
    wire [7:0]  m_tag    = sel ? b_tag    : a_tag;

    int checks = 0;
    int failures = 0;

    int          n_got, n_exp, busy_cyc, first_valid_k;
    logic [31:0] got_data [64];
    logic [7:0]  got_tag  [64];
    logic        got_last [64];
    logic [31:0] exp_data [64];
    logic [7:0]  exp_tag  [64];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
        end
    endtask

    task automatic build_exp(input int nregs, input int nmem, input logic [31:0] mem0,
                             input logic [31:0] mem1, input logic [31:0] mem2);
        logic [31:0] mv [3];
        mv[0] = mem0; mv[1] = mem1; mv[2] = mem2;
        n_exp = 0;
        if (NPC == 1) begin
            exp_data[n_exp] = 32'h1C; exp_tag[n_exp] = 8'h00; n_exp++;
        end
        for (int i = 0; i < nregs; i++) begin
            exp_data[n_exp] = 32'(10 * i); exp_tag[n_exp] = 8'h40 + 8'(i); n_exp++;
        end
        for (int i = 0; i < nmem; i++) begin
            exp_data[n_exp] = mv[i]; exp_tag[n_exp] = 8'h80 + 8'(i); n_exp++;
        end
    endtask

    task automatic cmp_stream();
        chk("word_count", 64'(n_got), 64'(n_exp));
        for (int i = 0; i < n_exp && i < n_got; i++) begin
            chk($sformatf("data[%0d]", i), 64'(got_data[i]), 64'(exp_data[i]));
            chk($sformatf("tag[%0d]", i), 64'(got_tag[i]), 64'(exp_tag[i]));
            chk($sformatf("last[%0d]", i), 64'(got_last[i]), 64'(i == n_exp - 1));
        end
    endtask

    // mode 0: ready always high; mode 1: ready high on odd cycles only.
    // ovr_k: cycle to re-pulse snap_req; rst_k: cycle to assert reset; lastreq: pulse on last accept.
    task automatic run_stream(input int mode, input int ovr_k, input int rst_k, input bit lastreq);
        int k;
        logic pv_stall;
        logic [31:0] pd;
        logic [7:0] pt;
        logic pl;
        n_got = 0; busy_cyc = 0; first_valid_k = 0; pv_stall = 1'b0;
        pd = '0; pt = '0; pl = 1'b0;
        snap = 1'b1;
        @(negedge clk);
        for (k = 1; k < 200; k++) begin
            snap = 1'b0;
            if (k == 1) begin
                chk("start_freeze", 64'(m_freeze), 64'd1);
                chk("start_busy", 64'(m_busy), 64'd1);
                chk("start_ovr_clear", 64'(m_ovr), 64'd0);
                chk("start_valid", 64'(m_valid), 64'd0);
            end
            if (m_busy) busy_cyc++;
            if (m_valid && first_valid_k == 0) first_valid_k = k;
            if (pv_stall) begin
                chk("stall_data", 64'(m_data), 64'(pd));
                chk("stall_tag", 64'(m_tag), 64'(pt));
                chk("stall_last", 64'(m_last), 64'(pl));
            end
            if (!m_busy) break;
            if (k == rst_k) begin
                rst = 1'b1;
                #1;
                chk("rst_valid", 64'(m_valid), 64'd0);
                chk("rst_last", 64'(m_last), 64'd0);
                chk("rst_data", 64'(m_data), 64'd0);
                chk("rst_tag", 64'(m_tag), 64'd0);
                chk("rst_busy", 64'(m_busy), 64'd0);
                chk("rst_freeze", 64'(m_freeze), 64'd0);
                chk("rst_rf", 64'(m_rf), 64'd0);
                chk("rst_dm", 64'(m_dm), 64'd0);
                $display("reset asserted mid-stream after %0d words", n_got);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            out_ready = (mode == 0) ? 1'b1 : (k % 2 == 1);
            if (k == ovr_k) snap = 1'b1;
            if (m_valid && out_ready) begin
                if (n_got < 64) begin
                    got_data[n_got] = m_data; got_tag[n_got] = m_tag; got_last[n_got] = m_last;
                end
                $display("word %0d tag=0x%02h data=0x%0h last=%0b", n_got, m_tag, m_data, m_last);
                n_got++;
                if (lastreq && m_last) snap = 1'b1;
            end
            pv_stall = m_valid && !out_ready;
            pd = m_data; pt = m_tag; pl = m_last;
            @(negedge clk);
        end
        chk("stream_done_busy", 64'(m_busy), 64'd0);
        snap = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; snap = 1'b0; out_ready = 1'b1; sel = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_freeze", 64'(m_freeze), 64'd0);
        chk("reset_busy", 64'(m_busy), 64'd0);
        chk("reset_ovr", 64'(m_ovr), 64'd0);
        chk("reset_valid", 64'(m_valid), 64'd0);
        chk("reset_last", 64'(m_last), 64'd0);
        chk("reset_data", 64'(m_data), 64'd0);
        chk("reset_tag", 64'(m_tag), 64'd0);
        chk("reset_rf", 64'(m_rf), 64'd0);
        chk("reset_dm", 64'(m_dm), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full-rate dump.
        build_exp(8, 2, 32'd5, 32'd9, 32'd0);
        run_stream(0, -1, -1, 1'b0);
        cmp_stream();
        chk("busy_cycles_fullrate", 64'(busy_cyc), 64'(NA + 2));
        chk("first_valid_cycle", 64'(first_valid_k), 64'd3);
        chk("no_overrun", 64'(m_ovr), 64'd0);
        chk("idle_rf_addr", 64'(m_rf), 64'd0);

        // Alternating backpressure, including a stalled last word.
        run_stream(1, -1, -1, 1'b0);
        cmp_stream();
        chk("busy_cycles_toggle", 64'(busy_cyc), 64'(2 * NA + 1));

        // Re-request during word 3.
        run_stream(0, 6, -1, 1'b0);
        cmp_stream();
        chk("overrun_set", 64'(m_ovr), 64'd1);

        // A fresh request clears the flag (checked at stream start too).
        run_stream(0, -1, -1, 1'b0);
        cmp_stream();
        chk("overrun_cleared", 64'(m_ovr), 64'd0);

        // Reset while word 5 is presented, then a complete stream.
        run_stream(0, -1, 8, 1'b0);
        chk("post_rst_ovr", 64'(m_ovr), 64'd0);
        run_stream(0, -1, -1, 1'b0);
        cmp_stream();

        // Request coinciding with acceptance of the last word is ignored.
        run_stream(0, -1, -1, 1'b1);
        cmp_stream();
        chk("lastreq_overrun", 64'(m_ovr), 64'd1);
        @(negedge clk);
        chk("lastreq_stays_idle", 64'(m_busy), 64'd0);

        // Offset memory window on instance B.
        sel = 1'b1;
        @(negedge clk);
        build_exp(2, 3, 32'h100, 32'h104, 32'h108);
        run_stream(0, -1, -1, 1'b0);
        cmp_stream();
        chk("b_busy_cycles", 64'(busy_cyc), 64'(NB + 2));
        run_stream(1, -1, -1, 1'b0);
        cmp_stream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_snapshot_streamer.md
# pipeline_snapshot_streamer

Hardware producer for the architectural-state dumps that the datapath bench currently pulls out by hierarchical peeking. On a snapshot request it stalls the pipeline and reads the register file and selected data-memory words through dedicated read ports. It then streams them out one word per cycle over a valid/ready interface, each word tagged with its source. It sits beside `pipeline_datapath` and feeds a debug FIFO/UART bridge.

## Interface

Parameters:
- DATA_W, 32, width of register/memory words and of out_data
- NREGS, 8, number of registers dumped (indices 0..NREGS-1, NREGS ≤ 64)
- MEM_WORDS, 2, number of memory words dumped (≤ 64)
- MEM_BASE, 0, byte address of first dumped memory word
- ADDR_W, 32, data-memory address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- snap_req  in  1  request a snapshot; sampled each cycle
- freeze  out  1  stall request to datapath (holds PC/pipeline regs and blocks RF/DMEM writes)
- busy  out  1  snapshot in progress
- req_overrun  out  1  sticky: snap_req seen while busy
- rf_raddr  out  6  register-file debug read address
- rf_rdata  in  DATA_W  combinational read data for rf_raddr
- dm_raddr  out  ADDR_W  data-memory debug read byte address
- dm_rdata  in  DATA_W  combinational read data for dm_raddr
- pc_in  in  32  current PC (present only with SNAP_PC_EN)
- out_valid  out  1  out_data/out_tag/out_last valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  DATA_W  dumped word
- out_tag  out  8  [7:6] kind (00 PC, 01 reg, 10 mem), [5:0] index
- out_last  out  1  final word of the snapshot

## Operation

- States: IDLE, SETTLE, PCW (macro only), REGS, MEM, DRAIN.
- IDLE: snap_req=1 → SETTLE. Set freeze=busy=1. Clear req_overrun. Clear idx.
- SETTLE: one cycle, so in-flight writeback completes. Then → PCW if the macro is defined, else REGS.
- Output register loads when slot free: `!out_valid || out_ready`. If no load, state/idx hold.
- PCW: load {pc_in, tag 00_000000} → REGS.
- REGS: rf_raddr=idx; load {rf_rdata, tag 01_idx}. idx increments. At idx=NREGS-1, idx clears → MEM.
- MEM: dm_raddr = MEM_BASE + 4*idx (ADDR_W wrap); load {dm_rdata, tag 10_idx}. At idx=MEM_WORDS-1 set out_last → DRAIN.
- If MEM_WORDS=0, REGS loads the last reg with out_last and goes → DRAIN directly.
- DRAIN: when the last word is accepted → IDLE. freeze, busy, out_valid and out_last all drop on that edge.
- snap_req while busy: ignored, sets req_overrun.
- rf_raddr/dm_raddr are 0 outside REGS/MEM.

## Timing

- Reset: state IDLE. freeze, busy, req_overrun, out_valid and out_last are 0. out_data, out_tag, rf_raddr and dm_raddr are 0.
- Request sampled at edge E. freeze/busy rise after E. First out_valid after E+2.
- With out_ready held high: out_valid is high for N consecutive cycles. N = NREGS + MEM_WORDS (+1 with macro). busy lasts N+2 cycles.
- Backpressure: out_data, out_tag and out_last are stable while out_valid && !out_ready. No word is dropped or duplicated.
- out_ready low in the same cycle the last word is presented: stay in DRAIN.
- Reset mid-snapshot: immediate return to reset values. A partial stream is abandoned without out_last.
- snap_req high in the same cycle the last word is accepted: ignored (state not yet IDLE), req_overrun set.

## Configuration

- SNAP_PC_EN defined: pc_in port exists. A PC header word (tag 0x00) is emitted first, and N includes it.
- SNAP_PC_EN undefined: no pc_in port, no PCW state. The stream starts with R[0] (tag 0x40).

## Test plan

- Reset, RF R[i]=10*i, Mem[0]=5, Mem[4]=9, out_ready=1, pulse snap_req → 10 words: tags 0x40..0x47 data 0..70, then 0x80/5, 0x81/9. out_last only on the last word. freeze high 12 cycles.
- Same with SNAP_PC_EN, pc_in=0x1C → first word tag 0x00 data 0x1C, 11 words total.
- Toggle out_ready 1/0 every cycle → identical word sequence. Outputs stable while stalled. busy stretches accordingly.
- Pulse snap_req again at word 3 → req_overrun=1 and the stream is unaffected. The next accepted request clears the flag.
- Assert rst at word 5 → all outputs 0 immediately. A new request then yields a complete stream from R[0].
- MEM_BASE=0x100, MEM_WORDS=3 → dm_raddr 0x100, 0x104, 0x108. out_last on tag 0x82.
